// File: rtl/mem_lsu_if.sv
// mem_lsu_if
// Data-memory port between the load/store unit and the data memory.
// Carries one word-addressed request with byte enables and its acknowledge.
//   mem_req   : access request, held until mem_ack or abandonment
//   mem_we    : 1 = write, 0 = read
//   mem_be    : byte enables, bit i selects lane i (bits 8i+7:8i)
//   mem_addr  : word-aligned byte address
//   mem_wdata : lane-replicated write data
//   mem_ack   : memory completed the current request
//   mem_rdata : read word, valid together with mem_ack
// master = load/store unit side, slave = memory side.
interface mem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu
// Load/store unit on the CPU side of the data-memory port. Takes one
// byte/half/word access from the datapath, checks type and alignment,
// issues a word-addressed memory request with byte enables, waits for the
// acknowledge (or a timeout) and returns extended load data or a store
// completion as a one-cycle response pulse.
// Ports:
//   clk, rstn         : clock, asynchronous active-low reset
//   req_valid/ready   : datapath access handshake (ready only in IDLE)
//   req_wr            : 1 = store, 0 = load
//   req_rbits         : load type 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
//   req_wbits         : store type 00 sw, 01 sh, 10 sb
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data, 0 for stores and errors
//   resp_err          : misaligned, illegal type or timeout
//   mem               : data-memory port (master side)
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_rbits,
    input  logic [1:0]  req_wbits,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    mem_lsu_if.master   mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  rbits_q, rbits_d;
    logic [1:0]  off_q, off_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        bad_type;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Request decode: illegal encodings and alignment are judged on the
    // incoming fields so a bad access never reaches the memory.
    always_comb begin
        bad_type   = 1'b0;
        misaligned = 1'b0;
        if (req_wr) begin
            bad_type = (req_wbits == 2'b11);
            if (req_wbits == 2'b00)
                misaligned = (req_addr[1:0] != 2'b00);
            else if (req_wbits == 2'b01)
                misaligned = req_addr[0];
        end else begin
            bad_type = (req_rbits > 3'd4);
            if (req_rbits == 3'b000)
                misaligned = (req_addr[1:0] != 2'b00);
            else if (req_rbits == 3'b001 || req_rbits == 3'b010)
                misaligned = req_addr[0];
        end
    end

    // Store lane placement: narrow data is replicated across all lanes so
    // only the byte enables depend on the address offset.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        if (req_wr) begin
            case (req_wbits)
                2'b01: begin
                    st_be    = 4'b0011 << req_addr[1:0];
                    st_wdata = {2{req_wdata[15:0]}};
                end
                2'b10: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the latched offset/type.
    always_comb begin
        shifted  = mem.mem_rdata >> {off_q, 3'b000};
        load_val = mem.mem_rdata;
        case (rbits_q)
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {16'h0000, shifted[15:0]};
            3'b011:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'h000000, shifted[7:0]};
            default: load_val = mem.mem_rdata;
        endcase
    end

    // Next-state logic. Memory-side registers are only loaded when an access
    // is actually issued; response registers only change on entry to RESP so
    // they hold between responses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rbits_d      = rbits_q;
        off_d        = off_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad_type || misaligned) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = 8'd0;
                        rbits_d     = req_rbits;
                        off_d       = req_addr[1:0];
                        mem_we_d    = req_wr;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = st_be;
                        mem_wdata_d = st_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    state_d      = RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'h0 : load_val;
                end else if (cnt_q == LAST_CNT) begin
                    state_d      = RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            rbits_q      <= 3'd0;
            off_q        <= 2'd0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rbits_q      <= rbits_d;
            off_q        <= off_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // mem_req is decoded from the state so it falls as soon as reset hits.
    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit on the CPU side of the data-memory port: the initiator for byte/half/word loads and stores. Accepts one access from the datapath, checks alignment, drives a word-addressed memory request with byte enables, waits for the memory acknowledge, then returns sign- or zero-extended load data or a store completion. It sits between the EX/MEM stage control and the data memory.

## Interface
- TIMEOUT, 16: maximum cycles in ACCESS without `mem_ack` before an error response; valid range 2..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  datapath presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_rbits  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- req_wbits  in  2  store type: 00 sw, 01 sh, 10 sb.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, illegal type, or timeout.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completed the current request.
- mem_rdata  in  32  read word, valid with mem_ack.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at the clock edge, register wr, type, addr and wdata.
  - Illegal type (rbits 101..111 on a load, wbits 11 on a store) or misalignment (half with addr[0]=1, word with addr[1:0]≠0) -> RESP with err=1. No memory request is issued.
  - Otherwise -> ACCESS, timeout counter cleared.
- ACCESS: mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are registered and held stable throughout the state.
  - On mem_ack: capture the extracted load value -> RESP with err=0.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 without ack -> RESP with err=1 and rdata=0.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_rdata and resp_err hold their values until the next RESP.
- Store encoding, off = addr[1:0]:
  - sw: be=1111, wdata unchanged.
  - sh: be=0011<<off, wdata={2{wdata[15:0]}}.
  - sb: be=0001<<off, wdata={4{wdata[7:0]}}.
- Loads: mem_be=1111, mem_we=0. The selected byte/half is mem_rdata shifted right by 8·off, then sign-extended (lb, lh) or zero-extended (lbu, lhu).
- mem_ack outside ACCESS is ignored.

## Timing
- Reset (rstn low): state=IDLE; resp_valid, resp_err, mem_req and mem_we = 0; resp_rdata, mem_be, mem_addr and mem_wdata = 0. req_valid is ignored while rstn is low.
- Reset mid-ACCESS: mem_req drops asynchronously, no response is produced, and the in-flight access is abandoned.
- Accept at edge E: mem_req high in cycle E+1.
- mem_ack sampled high at edge E+k (k≥1): resp_valid high in cycle E+k+1. Minimum load/store latency is 2 cycles from acceptance to resp_valid.
- Error path (misaligned or illegal type): resp_valid in cycle E+1; mem_req is never asserted.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then resp_valid with err=1 in the next cycle.
- Throughput: at most one access per 3 cycles. req_ready is low in ACCESS and RESP; req_valid held across those states is accepted on return to IDLE.

## Test plan
- Reset then sw addr 0x10 data 0xDEADBEEF, mem_ack on the first mem_req cycle -> mem_addr=0x10, be=1111, wdata=0xDEADBEEF, resp_valid 2 cycles after acceptance, err=0.
- sb addr 0x13 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5. sh addr 0x12 data 0x1234 -> be=1100, wdata=0x12341234.
- Load mem_rdata=0x80F17F00 at addr 0x...1/2/3: lb -> 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80; lbu at 0x3 -> 0x00000080; lh at 0x2 -> 0xFFFF80F1; lhu at 0x2 -> 0x000080F1.
- lw addr 0x22, and lh addr 0x21 -> resp_valid the next cycle with err=1, rdata=0, mem_req never asserted. Load with rbits=111 -> same error response.
- mem_ack held low, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then resp_valid err=1. A mem_ack pulsed in IDLE afterward has no effect.
- rstn pulsed low during ACCESS -> mem_req=0 immediately, no resp_valid. The next request after reset completes normally.
